// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: result entry layout and source lane order.
package wb_pkg;

  localparam int TAG_W   = 5;
  localparam int DATA_W  = 16;
  localparam int NUM_SRC = 4;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Lane order doubles as arrival order within a single cycle.
  typedef enum logic [1:0] {
    SRC_A0 = 2'd0,
    SRC_A1 = 2'd1,
    SRC_M  = 2'd2,
    SRC_LS = 2'd3
  } src_e;

endpackage

// File: rtl/wb_queue.sv
// Circular overflow queue: 4-lane ordered push (compacted by valid mask), 0..2 entry pop.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 8
)
(
  input  logic                            ref_clk,
  input  logic                            rst_n,
  input  logic      [NUM_SRC-1:0]         push_vld_i,
  input  wb_entry_t [NUM_SRC-1:0]         push_ent_i,
  input  logic      [1:0]                 pop_cnt_i,
  output logic      [$clog2(DEPTH):0]     occ_o,
  output wb_entry_t                       head0_o,
  output wb_entry_t                       head1_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [2:0]       push_cnt;
  logic [PTR_W-1:0] wr_idx [NUM_SRC];

  // Each valid lane lands at tail + (number of valid lanes before it).
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      wr_idx[i] = tail_q + PTR_W'(push_cnt);
      push_cnt  = push_cnt + {2'b00, push_vld_i[i]};
    end
    tail_d = tail_q + PTR_W'(push_cnt);
    head_d = head_q + PTR_W'(pop_cnt_i);
    occ_d  = occ_q + CNT_W'(push_cnt) - CNT_W'(pop_cnt_i);
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge ref_clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_vld_i[i]) mem_q[wr_idx[i]] <= push_ent_i[i];
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rst_n) assert (occ_q <= CNT_W'(DEPTH));
  end

  assign occ_o   = occ_q;
  assign head0_o = mem_q[head_q];
  assign head1_o = mem_q[head_q + PTR_W'(1)];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: captures up to four tagged results per cycle and retires them
// in arrival order over two register-file write ports, queueing any overflow.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 8
)
(
  input  logic              ref_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] A0_in,
  input  logic [TAG_W-1:0]  A0_Rd_tag_in,
  input  logic [DATA_W-1:0] A1_in,
  input  logic [TAG_W-1:0]  A1_Rd_tag_in,
  input  logic [DATA_W-1:0] M_in,
  input  logic [TAG_W-1:0]  M_Rd_tag_in,
  input  logic [TAG_W-1:0]  LS_Rd_tag_in,
  input  logic [7:0]        wb_data,
  input  logic              mem_stall,
  output logic              wr0_en,
  output logic [TAG_W-1:0]  wr0_tag,
  output logic [DATA_W-1:0] wr0_data,
  output logic              wr1_en,
  output logic [TAG_W-1:0]  wr1_tag,
  output logic [DATA_W-1:0] wr1_data,
  output logic              wb_stall
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  wb_entry_t [NUM_SRC-1:0] in_ent;
  wb_entry_t [NUM_SRC-1:0] cap_q, cap_d;
  wb_entry_t [NUM_SRC-1:0] comp;
  logic      [NUM_SRC-1:0] cap_vld_q, cap_vld_d;
  logic      [NUM_SRC-1:0] push_vld;
  logic      [2:0]         rank [NUM_SRC];
  logic      [2:0]         cap_cnt;
  logic      [CNT_W-1:0]   occ;
  logic      [SUM_W-1:0]   pool_cnt;
  wb_entry_t               q_head0, q_head1;
  wb_entry_t               pool0, pool1;
  logic      [1:0]         ret_cnt, pop_cnt, cap_ret;
  logic                    capture_en;

  logic              wr0_en_q, wr0_en_d, wr1_en_q, wr1_en_d;
  logic [TAG_W-1:0]  wr0_tag_q, wr0_tag_d, wr1_tag_q, wr1_tag_d;
  logic [DATA_W-1:0] wr0_data_q, wr0_data_d, wr1_data_q, wr1_data_d;

  always_comb begin
    in_ent         = '0;
    in_ent[SRC_A0] = '{tag: A0_Rd_tag_in, data: A0_in};
    in_ent[SRC_A1] = '{tag: A1_Rd_tag_in, data: A1_in};
    in_ent[SRC_M]  = '{tag: M_Rd_tag_in,  data: M_in};
    in_ent[SRC_LS] = '{tag: LS_Rd_tag_in, data: {{(DATA_W-8){1'b0}}, wb_data}};
  end

  assign capture_en = !mem_stall && !wb_stall;

  always_comb begin
    cap_d     = '0;
    cap_vld_d = '0;
    if (capture_en) begin
      cap_d = in_ent;
      for (int i = 0; i < NUM_SRC; i++) cap_vld_d[i] = (in_ent[i].tag != '0);
    end
  end

  // Squeeze valid capture slots together; rank is each slot's position in the pool tail.
  always_comb begin
    comp    = '0;
    cap_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rank[i] = cap_cnt;
      if (cap_vld_q[i]) begin
        comp[cap_cnt[1:0]] = cap_q[i];
        cap_cnt            = cap_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    pool_cnt = SUM_W'(occ) + SUM_W'(cap_cnt);
    if (occ >= CNT_W'(2)) begin
      pool0 = q_head0;
      pool1 = q_head1;
    end else if (occ == CNT_W'(1)) begin
      pool0 = q_head0;
      pool1 = comp[0];
    end else begin
      pool0 = comp[0];
      pool1 = comp[1];
    end

    // Two writes to one register in a cycle would lose ordering, so split them.
    if (pool_cnt == '0)              ret_cnt = 2'd0;
    else if (pool_cnt == SUM_W'(1))  ret_cnt = 2'd1;
    else if (pool0.tag == pool1.tag) ret_cnt = 2'd1;
    else                             ret_cnt = 2'd2;

    pop_cnt = (occ >= CNT_W'(ret_cnt)) ? ret_cnt : occ[1:0];
    cap_ret = ret_cnt - pop_cnt;
    for (int i = 0; i < NUM_SRC; i++) begin
      push_vld[i] = cap_vld_q[i] && (rank[i] >= {1'b0, cap_ret});
    end
  end

  assign wb_stall = pool_cnt > SUM_W'(DEPTH - 4);

  always_comb begin
    wr0_en_d   = (ret_cnt != 2'd0);
    wr0_tag_d  = wr0_en_d ? pool0.tag  : '0;
    wr0_data_d = wr0_en_d ? pool0.data : '0;
    wr1_en_d   = (ret_cnt == 2'd2);
    wr1_tag_d  = wr1_en_d ? pool1.tag  : '0;
    wr1_data_d = wr1_en_d ? pool1.data : '0;
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q      <= '0;
      cap_vld_q  <= '0;
      wr0_en_q   <= 1'b0;
      wr0_tag_q  <= '0;
      wr0_data_q <= '0;
      wr1_en_q   <= 1'b0;
      wr1_tag_q  <= '0;
      wr1_data_q <= '0;
    end else begin
      cap_q      <= cap_d;
      cap_vld_q  <= cap_vld_d;
      wr0_en_q   <= wr0_en_d;
      wr0_tag_q  <= wr0_tag_d;
      wr0_data_q <= wr0_data_d;
      wr1_en_q   <= wr1_en_d;
      wr1_tag_q  <= wr1_tag_d;
      wr1_data_q <= wr1_data_d;
    end
  end

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .ref_clk    (ref_clk),
    .rst_n      (rst_n),
    .push_vld_i (push_vld),
    .push_ent_i (cap_q),
    .pop_cnt_i  (pop_cnt),
    .occ_o      (occ),
    .head0_o    (q_head0),
    .head1_o    (q_head1)
  );

  assign wr0_en   = wr0_en_q;
  assign wr0_tag  = wr0_tag_q;
  assign wr0_data = wr0_data_q;
  assign wr1_en   = wr1_en_q;
  assign wr1_tag  = wr1_tag_q;
  assign wr1_data = wr1_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: accepted results are queued in arrival order and a
// monitor pops them as the write ports fire; directed checks cover latency and stalls.
module tb_wb_arbiter;

  logic        ref_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] A0_in = '0, A1_in = '0, M_in = '0;
  logic [4:0]  A0_Rd_tag_in = '0, A1_Rd_tag_in = '0, M_Rd_tag_in = '0, LS_Rd_tag_in = '0;
  logic [7:0]  wb_data = '0;
  logic        mem_stall = 1'b0;
  logic        wr0_en, wr1_en, wb_stall;
  logic [4:0]  wr0_tag, wr1_tag;
  logic [15:0] wr0_data, wr1_data;

  int          checks = 0;
  int          errors = 0;
  logic [20:0] exp_q[$];
  logic        acc;
  int          s;

  wb_arbiter #(.DEPTH(8)) dut (
    .ref_clk      (ref_clk),
    .rst_n        (rst_n),
    .A0_in        (A0_in),
    .A0_Rd_tag_in (A0_Rd_tag_in),
    .A1_in        (A1_in),
    .A1_Rd_tag_in (A1_Rd_tag_in),
    .M_in         (M_in),
    .M_Rd_tag_in  (M_Rd_tag_in),
    .LS_Rd_tag_in (LS_Rd_tag_in),
    .wb_data      (wb_data),
    .mem_stall    (mem_stall),
    .wr0_en       (wr0_en),
    .wr0_tag      (wr0_tag),
    .wr0_data     (wr0_data),
    .wr1_en       (wr1_en),
    .wr1_tag      (wr1_tag),
    .wr1_data     (wr1_data),
    .wb_stall     (wb_stall)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pop_chk(input string name, input logic [20:0] act);
    logic [20:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected write actual tag=%0d data=%0h required=no write",
               name, act[20:16], act[15:0]);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s actual tag=%0d data=%0h required tag=%0d data=%0h",
                 name, act[20:16], act[15:0], e[20:16], e[15:0]);
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge; record accepted results in arrival order.
  task automatic cyc(input logic [4:0] t0, input logic [15:0] d0,
                     input logic [4:0] t1, input logic [15:0] d1,
                     input logic [4:0] tm, input logic [15:0] dm,
                     input logic [4:0] tl, input logic [7:0] bd,
                     input logic ms, output logic accepted);
    A0_Rd_tag_in = t0; A0_in = d0;
    A1_Rd_tag_in = t1; A1_in = d1;
    M_Rd_tag_in  = tm; M_in  = dm;
    LS_Rd_tag_in = tl; wb_data = bd;
    mem_stall    = ms;
    accepted     = !ms && !wb_stall;
    if (accepted) begin
      if (t0 != 0) exp_q.push_back({t0, d0});
      if (t1 != 0) exp_q.push_back({t1, d1});
      if (tm != 0) exp_q.push_back({tm, dm});
      if (tl != 0) exp_q.push_back({tl, 8'h00, bd});
    end
    @(negedge ref_clk);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  initial begin : monitor
    forever begin
      @(posedge ref_clk);
      #1;
      if (rst_n) begin
        if (wr0_en) pop_chk("wr0", {wr0_tag, wr0_data});
        if (wr1_en) begin
          chk("wr1_without_wr0", wr0_en, 1);
          pop_chk("wr1", {wr1_tag, wr1_data});
        end
        if (dut.occ > 4'd8) begin
          checks++;
          errors++;
          $display("FAIL occ_bound actual=%0d required<=8", dut.occ);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin : stim
    repeat (3) @(negedge ref_clk);
    chk("rst_wr0_en", wr0_en, 0);
    chk("rst_wr1_en", wr1_en, 0);
    chk("rst_wr0_tag", wr0_tag, 0);
    chk("rst_wr1_data", wr1_data, 0);
    chk("rst_wb_stall", wb_stall, 0);
    rst_n = 1'b1;
    idle(2);

    // single result
    cyc(5'd3, 16'h1234, 0, 0, 0, 0, 0, 0, 0, acc);
    chk("single_t1_en", wr0_en, 0);
    idle(1);
    chk("single_wr0_en", wr0_en, 1);
    chk("single_wr0_tag", wr0_tag, 3);
    chk("single_wr0_data", wr0_data, 16'h1234);
    chk("single_wr1_en", wr1_en, 0);
    idle(3);

    // four results in one cycle
    cyc(5'd1, 16'h1111, 5'd2, 16'h2222, 5'd4, 16'h4444, 5'd5, 8'hAB, 0, acc);
    chk("four_t1_en", {wr0_en, wr1_en}, 0);
    idle(1);
    chk("four_t2_en", {wr0_en, wr1_en}, 2'b11);
    chk("four_t2_tag0", wr0_tag, 1);
    chk("four_t2_tag1", wr1_tag, 2);
    idle(1);
    chk("four_t3_en", {wr0_en, wr1_en}, 2'b11);
    chk("four_t3_tag0", wr0_tag, 4);
    chk("four_t3_tag1", wr1_tag, 5);
    chk("four_t3_data1", wr1_data, 16'h00AB);
    idle(1);
    chk("four_t4_en", {wr0_en, wr1_en}, 0);
    idle(2);

    // same-tag pair
    cyc(5'd7, 16'd1, 5'd7, 16'd2, 0, 0, 0, 0, 0, acc);
    idle(1);
    chk("same_t2_wr0_en", wr0_en, 1);
    chk("same_t2_wr0", {wr0_tag, wr0_data}, {5'd7, 16'd1});
    chk("same_t2_wr1_en", wr1_en, 0);
    idle(1);
    chk("same_t3_wr0", {wr0_en, wr0_tag, wr0_data}, {1'b1, 5'd7, 16'd2});
    chk("same_t3_wr1_en", wr1_en, 0);
    idle(2);

    // mem_stall: queued results drain, nothing new captured
    cyc(5'd1, 16'h0101, 5'd2, 16'h0102, 5'd3, 16'h0103, 5'd4, 8'h04, 0, acc);
    cyc(5'd5, 16'h0105, 5'd6, 16'h0106, 5'd7, 16'h0107, 5'd8, 8'h08, 0, acc);
    chk("ms_t2_tags", {wr0_en, wr0_tag, wr1_en, wr1_tag}, {1'b1, 5'd1, 1'b1, 5'd2});
    cyc(5'd10, 16'hA0, 5'd11, 16'hA1, 5'd12, 16'hA2, 5'd13, 8'hA3, 1, acc);
    chk("ms_t3_tags", {wr0_en, wr0_tag, wr1_en, wr1_tag}, {1'b1, 5'd3, 1'b1, 5'd4});
    chk("ms_t3_wb_stall", wb_stall, 0);
    cyc(5'd10, 16'hA0, 5'd11, 16'hA1, 5'd12, 16'hA2, 5'd13, 8'hA3, 1, acc);
    chk("ms_t4_tags", {wr0_en, wr0_tag, wr1_en, wr1_tag}, {1'b1, 5'd5, 1'b1, 5'd6});
    chk("ms_t4_wb_stall", wb_stall, 0);
    cyc(5'd10, 16'hA0, 5'd11, 16'hA1, 5'd12, 16'hA2, 5'd13, 8'hA3, 1, acc);
    chk("ms_t5_tags", {wr0_en, wr0_tag, wr1_en, wr1_tag}, {1'b1, 5'd7, 1'b1, 5'd8});
    cyc(5'd10, 16'hA0, 5'd11, 16'hA1, 5'd12, 16'hA2, 5'd13, 8'hA3, 1, acc);
    chk("ms_t6_en", {wr0_en, wr1_en}, 0);
    idle(3);

    // saturation: stall first seen in the third presentation cycle, then alternates
    s = 0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("sat_stall_k%0d", k), wb_stall, (k >= 2 && k % 2 == 0));
      cyc(5'd1, {8'(s), 8'h01}, 5'd2, {8'(s), 8'h02}, 5'd3, {8'(s), 8'h03},
          5'd4, 8'(s), 0, acc);
      if (acc) s++;
    end
    idle(10);
    chk("sat_drained", exp_q.size(), 0);

    // reset mid-burst with five results queued
    cyc(5'd9, 16'h0901, 5'd9, 16'h0902, 5'd9, 16'h0903, 5'd9, 8'h04, 0, acc);
    cyc(5'd9, 16'h0911, 5'd9, 16'h0912, 5'd9, 16'h0913, 0, 0, 0, acc);
    idle(1);
    chk("rstb_occ_before", dut.occ, 5);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rstb_en", {wr0_en, wr1_en}, 0);
    chk("rstb_tags", {wr0_tag, wr1_tag}, 0);
    chk("rstb_data", {wr0_data, wr1_data}, 0);
    chk("rstb_wb_stall", wb_stall, 0);
    chk("rstb_occ", dut.occ, 0);
    repeat (2) @(negedge ref_clk);
    rst_n = 1'b1;
    idle(6);
    chk("rstb_after_en", {wr0_en, wr1_en}, 0);
    chk("rstb_after_occ", dut.occ, 0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
